// File: rtl/controller_pkg.sv
// controller_pkg: shared button indices and limits for controller_reader and controller_responder
package controller_pkg;
    localparam int BTN_UP          = 11;
    localparam int BTN_DOWN        = 10;
    localparam int BTN_LEFT        = 9;
    localparam int BTN_RIGHT       = 8;
    localparam int BTN_A           = 7;
    localparam int BTN_B           = 6;
    localparam int BTN_C           = 5;
    localparam int BTN_X           = 4;
    localparam int BTN_Y           = 3;
    localparam int BTN_Z           = 2;
    localparam int BTN_START       = 1;
    localparam int BTN_MODE        = 0;
    localparam int FCNT_MAX        = 4;
    localparam int DEFAULT_TIMEOUT = 75000;
endpackage

// File: rtl/controller_responder_select_sync.sv
// select_sync: 2-FF synchronizer for the select line with rise/fall pulses
module select_sync (
    input  logic clk,
    input  logic reset,
    input  logic select,
    output logic sel_s,
    output logic rise,
    output logic fall
);
    logic s1, s2, s_prev;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= select;
            s2     <= s1;
            s_prev <= s2;
        end
    end
    assign sel_s = s2;
    assign rise  = s2 & ~s_prev;
    assign fall  = ~s2 & s_prev;
endmodule

// File: rtl/controller_responder.sv
// controller_responder: 3/6-button pad emulator driving active-low pins; CONTROLLER_SIX_BUTTON_EN selects 6-button mode
module controller_responder
    import controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [11:0] buttons,
    input  logic        connected,
    output logic        PIN_UP_Z,
    output logic        PIN_DOWN_Y,
    output logic        PIN_LEFT_X,
    output logic        PIN_RIGHT_MODE,
    output logic        PIN_A_B,
    output logic        PIN_START_C,
    output logic [2:0]  phase
);
    logic        sel_s, rise, fall;
    logic [2:0]  fcnt, fcnt_nxt;
    logic [5:0]  pins, pins_nxt;
    logic [11:0] n;
    assign n = ~buttons;
    select_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .select(select),
        .sel_s (sel_s),
        .rise  (rise),
        .fall  (fall)
    );
`ifdef CONTROLLER_SIX_BUTTON_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle;
    logic          tmo;
    assign tmo = idle >= CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idle <= '0;
        else if (rise | fall)
            idle <= '0;
        else if (idle != CW'(TIMEOUT_CYCLES))
            idle <= idle + CW'(1);
    end
    // The mux uses the next count so a new phase shows without a stale cycle.
    always_comb begin
        fcnt_nxt = fall ? (fcnt == 3'(FCNT_MAX) ? fcnt : fcnt + 3'd1) : (!rise && tmo) ? 3'd0 : fcnt;
        pins_nxt = sel_s ? (fcnt_nxt == 3'd3
                      ? {n[BTN_Z], n[BTN_Y], n[BTN_X], n[BTN_MODE], n[BTN_B], n[BTN_C]}
                      : {n[BTN_UP], n[BTN_DOWN], n[BTN_LEFT], n[BTN_RIGHT], n[BTN_B], n[BTN_C]})
                 : {fcnt_nxt == 3'd4 ? 4'hF : fcnt_nxt == 3'd3 ? 4'h0 : {n[BTN_UP], n[BTN_DOWN], 2'b00},
                    n[BTN_A], n[BTN_START]};
    end
`else
    logic unused_sig;
    assign unused_sig = &{rise, fall, n[BTN_X], n[BTN_Y], n[BTN_Z], n[BTN_MODE], TIMEOUT_CYCLES[0]};
    always_comb begin
        fcnt_nxt = 3'd0;
        pins_nxt = sel_s ? {n[BTN_UP], n[BTN_DOWN], n[BTN_LEFT], n[BTN_RIGHT], n[BTN_B], n[BTN_C]}
                         : {n[BTN_UP], n[BTN_DOWN], 2'b00, n[BTN_A], n[BTN_START]};
    end
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pins <= '1;
            fcnt <= '0;
        end else begin
            pins <= connected ? pins_nxt : '1;
            fcnt <= fcnt_nxt;
        end
    end
    assign {PIN_UP_Z, PIN_DOWN_Y, PIN_LEFT_X, PIN_RIGHT_MODE, PIN_A_B, PIN_START_C} = pins;
    assign phase = fcnt;
endmodule

// File: tb/tb_controller_responder.sv
// tb_controller_responder: table-driven check of controller_responder in either build of CONTROLLER_SIX_BUTTON_EN
module tb_controller_responder;
    logic        clk = 1'b0;
    logic        reset, select, connected;
    logic [11:0] buttons;
    logic        PIN_UP_Z, PIN_DOWN_Y, PIN_LEFT_X, PIN_RIGHT_MODE, PIN_A_B, PIN_START_C;
    logic [2:0]  phase;
    logic [5:0]  pins;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    controller_responder #(.TIMEOUT_CYCLES(100)) dut (
        .clk           (clk),
        .reset         (reset),
        .select        (select),
        .buttons       (buttons),
        .connected     (connected),
        .PIN_UP_Z      (PIN_UP_Z),
        .PIN_DOWN_Y    (PIN_DOWN_Y),
        .PIN_LEFT_X    (PIN_LEFT_X),
        .PIN_RIGHT_MODE(PIN_RIGHT_MODE),
        .PIN_A_B       (PIN_A_B),
        .PIN_START_C   (PIN_START_C),
        .phase         (phase)
    );
    assign pins = {PIN_UP_Z, PIN_DOWN_Y, PIN_LEFT_X, PIN_RIGHT_MODE, PIN_A_B, PIN_START_C};

    // p6/f6: 6-button expectations, p3: 3-button pins (phase always 0 there)
    typedef struct {
        logic        sel;
        logic [11:0] btn;
        logic        con;
        int          hold;
        logic [5:0]  p6;
        logic [2:0]  f6;
        logic [5:0]  p3;
    } vec_t;
    vec_t v[20];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic hold(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic sel_edge(input logic val);
        select = val;
        hold(3);
    endtask

    initial begin
        logic [5:0] ep;
        logic [2:0] ef;
        v[0]  = '{1'b1, 12'h800, 1'b1, 3,   6'b011111, 3'd0, 6'b011111};
        v[1]  = '{1'b1, 12'hFFF, 1'b1, 20,  6'b000000, 3'd0, 6'b000000};
        v[2]  = '{1'b0, 12'hFFF, 1'b1, 20,  6'b000000, 3'd1, 6'b000000};
        v[3]  = '{1'b1, 12'hFFF, 1'b1, 20,  6'b000000, 3'd1, 6'b000000};
        v[4]  = '{1'b0, 12'hFFF, 1'b1, 20,  6'b000000, 3'd2, 6'b000000};
        v[5]  = '{1'b1, 12'hFFF, 1'b1, 20,  6'b000000, 3'd2, 6'b000000};
        v[6]  = '{1'b0, 12'hFFF, 1'b1, 20,  6'b000000, 3'd3, 6'b000000};
        v[7]  = '{1'b1, 12'hFFF, 1'b1, 20,  6'b000000, 3'd3, 6'b000000};
        v[8]  = '{1'b0, 12'hFFF, 1'b1, 20,  6'b111100, 3'd4, 6'b000000};
        v[9]  = '{1'b1, 12'hFFF, 1'b1, 20,  6'b000000, 3'd4, 6'b000000};
        v[10] = '{1'b0, 12'hFFF, 1'b1, 20,  6'b111100, 3'd4, 6'b000000};
        v[11] = '{1'b0, 12'hFFF, 1'b1, 120, 6'b000000, 3'd0, 6'b000000};
        v[12] = '{1'b1, 12'h00F, 1'b1, 20,  6'b111111, 3'd0, 6'b111111};
        v[13] = '{1'b0, 12'h00F, 1'b1, 20,  6'b110010, 3'd1, 6'b110010};
        v[14] = '{1'b1, 12'h00F, 1'b0, 20,  6'b111111, 3'd1, 6'b111111};
        v[15] = '{1'b0, 12'h00F, 1'b0, 20,  6'b111111, 3'd2, 6'b111111};
        v[16] = '{1'b1, 12'h00F, 1'b1, 20,  6'b111111, 3'd2, 6'b111111};
        v[17] = '{1'b0, 12'h00F, 1'b1, 20,  6'b000010, 3'd3, 6'b110010};
        v[18] = '{1'b1, 12'h00F, 1'b1, 20,  6'b001011, 3'd3, 6'b111111};
        v[19] = '{1'b0, 12'h00F, 1'b1, 20,  6'b111110, 3'd4, 6'b110010};

        reset = 1'b0;
        select = 1'b1;
        buttons = 12'h800;
        connected = 1'b1;
        hold(3);
        chk("reset_pins", 8'(pins), 8'h3F);
        chk("reset_phase", 8'(phase), 8'h00);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            select = v[i].sel;
            buttons = v[i].btn;
            connected = v[i].con;
            hold(v[i].hold);
`ifdef CONTROLLER_SIX_BUTTON_EN
            ep = v[i].p6;
            ef = v[i].f6;
`else
            ep = v[i].p3;
            ef = 3'd0;
`endif
            chk($sformatf("vec%0d_pins", i), 8'(pins), 8'(ep));
            chk($sformatf("vec%0d_phase", i), 8'(phase), 8'(ef));
        end

        // asynchronous reset mid-operation
        reset = 1'b0;
        #1;
        chk("midreset_pins", 8'(pins), 8'h3F);
        chk("midreset_phase", 8'(phase), 8'h00);
        select = 1'b1;
        buttons = 12'h000;
        hold(2);
        reset = 1'b1;
        hold(3);
        chk("idle_pins", 8'(pins), 8'h3F);

        buttons = 12'h800;
        hold(1);
        chk("btn_lat_press", 8'(pins), 8'b011111);
        buttons = 12'h000;
        hold(1);
        chk("btn_lat_release", 8'(pins), 8'h3F);

        select = 1'b0;
        hold(2);
        chk("sel_lat_2clk", 8'(pins), 8'h3F);
        hold(1);
        chk("sel_lat_3clk", 8'(pins), 8'b110011);
`ifdef CONTROLLER_SIX_BUTTON_EN
        chk("sel_lat_phase", 8'(phase), 8'd1);
        hold(7);
        sel_edge(1'b1); hold(7);
        sel_edge(1'b0); hold(7);
        chk("to_pre_phase", 8'(phase), 8'd2);
        sel_edge(1'b1); hold(7);
        sel_edge(1'b0);
        chk("to_start_phase", 8'(phase), 8'd3);
        hold(99);
        chk("to_99_phase", 8'(phase), 8'd3);
        hold(1);
        chk("to_100_phase", 8'(phase), 8'd0);
        chk("to_100_pins", 8'(pins), 8'b110011);
        for (int k = 0; k < 3; k++) begin
            sel_edge(1'b1); hold(7);
            sel_edge(1'b0); hold(7);
        end
        sel_edge(1'b1);
        chk("race_start_phase", 8'(phase), 8'd3);
        hold(97);
        select = 1'b0;
        hold(2);
        chk("race_99_phase", 8'(phase), 8'd3);
        hold(1);
        chk("race_100_phase", 8'(phase), 8'd4);
`else
        chk("sel_lat_phase", 8'(phase), 8'd0);
        buttons = 12'h0C0;
        hold(7);
        for (int k = 0; k < 3; k++) begin
            sel_edge(1'b1); hold(7);
            sel_edge(1'b0); hold(7);
        end
        chk("low4_pins", 8'(pins), 8'b110001);
        chk("low4_phase", 8'(phase), 8'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
